// File: rtl/adc_rx_pkg.sv
// Shared types and constants for the ADC serial receive path.
package adc_rx_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/adc_rx_fifo.sv
// First-word-fall-through word FIFO; dout reads 0 whenever the FIFO is empty.
import adc_rx_pkg::*;

module adc_rx_fifo #(
    parameter int W     = WORD_W,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/adc_stream_rx.sv
// ADC serial stream receiver: synchronizes the bit clock/data, assembles
// MSB-first samples, packs two per word and queues words for the host pipe.
import adc_rx_pkg::*;

module adc_stream_rx #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [31:0]                    nsam,
    input  logic                           clk_s_d_out,
    input  logic                           adc_out,
    input  logic                           rd,
    output logic [31:0]                    dout,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int BW = $clog2(SAMPLE_W);

    logic                  sclk_p0, sclk_p1, sclk_p2;
    logic                  sdat_p0, sdat_p1;
    logic                  rise;

    state_t                state;
    logic [BW-1:0]         bitcnt;
    logic [31:0]           samp_cnt;
    logic [31:0]           samp_nxt;
    logic [31:0]           nsam_q;
    logic                  half;
    logic                  fin_p1;
    logic                  push_p1;

    logic [SAMPLE_W-1:0]   shift_p0;
    logic [SAMPLE_W-1:0]   hi_p0;
    logic [SAMPLE_W-1:0]   sample;
    logic [WORD_W-1:0]     word_p1;

    logic                  cap_en;
    logic                  samp_done;
    logic                  last_samp;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  ovf_evt;
    logic                  unf_evt;

    // Stage p0/p1: two-flop synchronizers; p2 holds the previous synced clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            sdat_p0 <= 1'b0;
            sdat_p1 <= 1'b0;
        end else begin
            sclk_p0 <= clk_s_d_out;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            sdat_p0 <= adc_out;
            sdat_p1 <= sdat_p0;
        end
    end

    // sdat_p1 was sampled on the same clk edge as sclk_p1, so it is the bit
    // that belongs to this rise.
    assign rise      = sclk_p1 & ~sclk_p2;
    assign cap_en    = (state == CAPTURE) && rise && !fin_p1;
    assign samp_done = cap_en && (bitcnt == BW'(SAMPLE_W-1));
    assign sample    = {shift_p0[SAMPLE_W-2:0], sdat_p1};
    assign samp_nxt  = samp_cnt + 32'd1;
    assign last_samp = (samp_nxt == nsam_q);

    // Stage p1: assembled word, pushed one cycle after its last bit.
    always_ff @(posedge clk) begin
        if (cap_en)
            shift_p0 <= sample;
        if (samp_done && !half)
            hi_p0 <= sample;
        if (samp_done)
            word_p1 <= half ? {hi_p0, sample} : {sample, {SAMPLE_W{1'b0}}};
    end

    assign fifo_push = push_p1 && !abort;
    assign ovf_evt   = fifo_push && fifo_full && !(rd && !fifo_empty);
    assign unf_evt   = rd && fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bitcnt    <= '0;
            samp_cnt  <= '0;
            nsam_q    <= '0;
            half      <= 1'b0;
            fin_p1    <= 1'b0;
            push_p1   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            push_p1 <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                bitcnt   <= '0;
                samp_cnt <= '0;
                half     <= 1'b0;
                fin_p1   <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            nsam_q    <= nsam;
                            bitcnt    <= '0;
                            samp_cnt  <= '0;
                            half      <= 1'b0;
                            fin_p1    <= 1'b0;
                            overflow  <= 1'b0;
                            underflow <= 1'b0;
                            if (nsam == 32'd0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= CAPTURE;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (fin_p1) begin
                            state  <= DONE;
                            fin_p1 <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else if (cap_en) begin
                            if (samp_done) begin
                                bitcnt   <= '0;
                                samp_cnt <= samp_nxt;
                                half     <= ~half;
                                if (half || last_samp) push_p1 <= 1'b1;
                                if (last_samp)         fin_p1  <= 1'b1;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
            // Events in the start cycle still register after the clear.
            if (ovf_evt) overflow  <= 1'b1;
            if (unf_evt) underflow <= 1'b1;
        end
    end

    adc_rx_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (fifo_push),
        .pop   (rd),
        .din   (word_p1),
        .dout  (dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_adc_stream_rx.sv
// Directed bench for adc_stream_rx: packing, odd counts, overflow, underflow,
// reset and abort during capture, and zero-length requests.
module tb_adc_stream_rx;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] nsam;
    logic        clk_s_d_out;
    logic        adc_out;
    logic        rd;
    logic [31:0] dout;
    logic [4:0]  fifo_count;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;

    adc_stream_rx #(
        .SAMPLE_W   (16),
        .FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .nsam        (nsam),
        .clk_s_d_out (clk_s_d_out),
        .adc_out     (adc_out),
        .rd          (rd),
        .dout        (dout),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, required finish within 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        clk_s_d_out = 1'b0;
        adc_out     = b;
        repeat (3) @(negedge clk);
        clk_s_d_out = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_sample(input logic [15:0] s);
        for (int i = 15; i >= 0; i--) send_bit(s[i]);
    endtask

    task automatic pulse_start(input logic [31:0] n);
        nsam  = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // Waits a bounded number of cycles for done, then checks it lasts one cycle.
    task automatic wait_done(input string tag, input logic [31:0] exp_count);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, {31'd0, found}, 32'd1);
        if (found) begin
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            check({tag, "_count_at_done"}, {27'd0, fifo_count}, exp_count);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int seen;
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        nsam        = 32'd0;
        clk_s_d_out = 1'b0;
        adc_out     = 1'b0;
        rd          = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout",  dout, 32'd0);
        check("rst_count", {27'd0, fifo_count}, 32'd0);
        check("rst_flags", {28'd0, busy, done, overflow, underflow}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Even count: two full words.
        pulse_start(32'd4);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_sample(16'h1234);
        send_sample(16'hABCD);
        send_sample(16'h0001);
        send_sample(16'hFFFF);
        wait_done("t1", 32'd2);
        check("t1_w0", dout, 32'h1234ABCD);
        pulse_rd();
        check("t1_w1", dout, 32'h0001FFFF);
        pulse_rd();
        check("t1_empty_dout", dout, 32'd0);
        check("t1_empty_count", {27'd0, fifo_count}, 32'd0);

        // Odd count: last word zero-padded.
        pulse_start(32'd3);
        send_sample(16'hAAAA);
        send_sample(16'h5555);
        send_sample(16'h0F0F);
        wait_done("t2", 32'd2);
        check("t2_w0", dout, 32'hAAAA5555);
        pulse_rd();
        check("t2_w1", dout, 32'h0F0F0000);
        pulse_rd();
        check("t2_ovf", {31'd0, overflow}, 32'd0);

        // Overflow: 20 words into a 16-word FIFO.
        pulse_start(32'd40);
        for (int k = 0; k < 40; k++) send_sample(16'h1000 + 16'(k));
        wait_done("t3", 32'd16);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("t3_w%0d", j), dout,
                  {16'h1000 + 16'(2*j), 16'h1000 + 16'(2*j+1)});
            pulse_rd();
        end
        check("t3_drained", {27'd0, fifo_count}, 32'd0);

        // Underflow on empty read.
        check("t4_unf_before", {31'd0, underflow}, 32'd0);
        pulse_rd();
        check("t4_unf", {31'd0, underflow}, 32'd1);
        check("t4_dout", dout, 32'd0);
        check("t4_count", {27'd0, fifo_count}, 32'd0);

        // Asynchronous reset part-way through a sample.
        pulse_start(32'd2);
        check("t5_unf_cleared", {31'd0, underflow}, 32'd0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        pulse_rd();
        check("t5_pre_flags", {28'd0, busy, done, overflow, underflow}, 32'b1001);
        clk_s_d_out = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("t5_rst_dout", dout, 32'd0);
        check("t5_rst_count", {27'd0, fifo_count}, 32'd0);
        check("t5_rst_flags", {28'd0, busy, done, overflow, underflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        pulse_start(32'd2);
        send_sample(16'hC3C3);
        send_sample(16'h1818);
        wait_done("t5", 32'd1);
        check("t5_word", dout, 32'hC3C31818);

        // Abort mid-capture; residual word survives start, then is flushed.
        pulse_start(32'd4);
        check("t6_residual", dout, 32'hC3C31818);
        send_sample(16'h0123);
        send_sample(16'h4567);
        send_bit(1'b0);
        check("t6_count_pre", {27'd0, fifo_count}, 32'd2);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_count", {27'd0, fifo_count}, 32'd0);
        check("t6_dout", dout, 32'd0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("t6_no_done", 32'(seen), 32'd0);

        // Zero-length request completes immediately.
        pulse_start(32'd0);
        check("t7_done", {31'd0, done}, 32'd1);
        check("t7_busy", {31'd0, busy}, 32'd0);
        check("t7_count", {27'd0, fifo_count}, 32'd0);
        @(negedge clk);
        check("t7_done_clear", {31'd0, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
